// File: rtl/mc_stage_sequencer.sv
// Stage sequencer for the multicycle RV32I core: decodes the fetched
// instruction into a microcode index, walks the stage index through
// IF/ID/EX/MEM/WB with per-class skips, and stalls on memory ready.
// {inst_idx, stage} addresses the microcode ROM.
module mc_stage_sequencer #(
  parameter int CNT_WIDTH  = 32,
  parameter int WAIT_LIMIT = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [31:0]          imem_rdata,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 halt_req,
  output logic [2:0]           stage,
  output logic [4:0]           inst_idx,
  output logic                 ir_we,
  output logic                 inst_end,
  output logic [CNT_WIDTH-1:0] retired,
  output logic                 halted,
  output logic                 illegal,
  output logic                 timeout
);

  // Counter only needs to reach WAIT_LIMIT-1; the limit cycle itself trips.
  localparam int WaitW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);

  typedef enum logic [1:0] {RUN, HALT, ERR} state_e;
  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } stage_e;

  state_e               state_q, state_d;
  stage_e               stage_q, stage_d;
  logic [4:0]           idx_q, idx_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 halted_q, halted_d;
  logic                 illegal_q, illegal_d;
  logic                 timeout_q, timeout_d;
  logic [WaitW-1:0]     wait_q, wait_d;

  logic       dec_valid;
  logic [4:0] dec_idx;
  logic       waiting;
  logic       ir_we_c;
  logic       inst_end_c;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  // Register-number fields do not affect the microcode index.
  logic unused_rdata_bits;

  assign opc = imem_rdata[6:0];
  assign f3  = imem_rdata[14:12];
  assign f7  = imem_rdata[31:25];
  assign unused_rdata_bits = ^{imem_rdata[24:15], imem_rdata[11:7]};

  // Decode the fetched word into its microcode index, flagging encodings with no index.
  always_comb begin
    dec_valid = 1'b1;
    dec_idx   = 5'd0;
    case (opc)
      7'b0110011: begin
        case (f3)
          3'b000: begin
            if (f7 == 7'b0000000)      dec_idx = 5'd0;
            else if (f7 == 7'b0100000) dec_idx = 5'd1;
            else                       dec_valid = 1'b0;
          end
          3'b101: begin
            if (f7 == 7'b0000000)      dec_idx = 5'd8;
            else if (f7 == 7'b0100000) dec_idx = 5'd9;
            else                       dec_valid = 1'b0;
          end
          default: begin
            if (f7 != 7'b0000000) dec_valid = 1'b0;
            case (f3)
              3'b010:  dec_idx = 5'd2;
              3'b011:  dec_idx = 5'd3;
              3'b100:  dec_idx = 5'd4;
              3'b110:  dec_idx = 5'd5;
              3'b111:  dec_idx = 5'd6;
              default: dec_idx = 5'd7;
            endcase
          end
        endcase
      end
      7'b0010011: begin
        case (f3)
          3'b000: dec_idx = 5'd10;
          3'b010: dec_idx = 5'd12;
          3'b011: dec_idx = 5'd13;
          3'b100: dec_idx = 5'd14;
          3'b110: dec_idx = 5'd15;
          3'b111: dec_idx = 5'd16;
          3'b001: begin
            if (f7 == 7'b0000000) dec_idx = 5'd17;
            else                  dec_valid = 1'b0;
          end
          default: begin
            if (f7 == 7'b0000000)      dec_idx = 5'd18;
            else if (f7 == 7'b0100000) dec_idx = 5'd19;
            else                       dec_valid = 1'b0;
          end
        endcase
      end
      7'b0000011: begin
        if (f3 == 3'b010) dec_idx = 5'd20;
        else              dec_valid = 1'b0;
      end
      7'b0100011: begin
        if (f3 == 3'b010) dec_idx = 5'd21;
        else              dec_valid = 1'b0;
      end
      7'b1100111: dec_idx = 5'd22;
      7'b1101111: dec_idx = 5'd23;
      7'b1100011: begin
        case (f3)
          3'b000, 3'b001, 3'b100, 3'b101: dec_idx = 5'd24;
          3'b110, 3'b111:                 dec_idx = 5'd25;
          default:                        dec_valid = 1'b0;
        endcase
      end
      7'b0110111: dec_idx = 5'd26;
      7'b0010111: dec_idx = 5'd27;
      default:    dec_valid = 1'b0;
    endcase
  end

  // Next-state, stage walk, wait counting and the fetch/commit strobes.
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    idx_d      = idx_q;
    retired_d  = retired_q;
    halted_d   = halted_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    wait_d     = wait_q;
    waiting    = 1'b0;
    ir_we_c    = 1'b0;
    inst_end_c = 1'b0;

    if (state_q == RUN) begin
      case (stage_q)
        ST_IF: begin
          if (imem_ready) begin
            ir_we_c = 1'b1;
            wait_d  = '0;
            if (dec_valid) begin
              idx_d = dec_idx;
              if (dec_idx == 5'd26)                         stage_d = ST_WB;
              else if (dec_idx == 5'd23 || dec_idx == 5'd27) stage_d = ST_EX;
              else                                          stage_d = ST_ID;
            end else begin
              state_d   = ERR;
              illegal_d = 1'b1;
              stage_d   = ST_IF;
            end
          end else if (halt_req) begin
            state_d  = HALT;
            halted_d = 1'b1;
            wait_d   = '0;
          end else begin
            waiting = 1'b1;
          end
        end
        ST_ID: begin
          stage_d = ST_EX;
          wait_d  = '0;
        end
        ST_EX: begin
          wait_d = '0;
          if (idx_q == 5'd24 || idx_q == 5'd25)      inst_end_c = 1'b1;
          else if (idx_q == 5'd20 || idx_q == 5'd21) stage_d = ST_MEM;
          else                                       stage_d = ST_WB;
        end
        ST_MEM: begin
          if (dmem_ready) begin
            wait_d = '0;
            if (idx_q == 5'd21) inst_end_c = 1'b1;
            else                stage_d = ST_WB;
          end else begin
            waiting = 1'b1;
          end
        end
        ST_WB: begin
          inst_end_c = 1'b1;
        end
        default: begin
          stage_d = ST_IF;
        end
      endcase

      if (inst_end_c) begin
        retired_d = retired_q + CNT_WIDTH'(1);
        stage_d   = ST_IF;
        wait_d    = '0;
        if (halt_req) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end
      end

      if (waiting) begin
        if (wait_q == WaitW'(WAIT_LIMIT - 1)) begin
          state_d   = ERR;
          timeout_d = 1'b1;
          stage_d   = ST_IF;
          wait_d    = '0;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
    end else begin
      stage_d = ST_IF;
      wait_d  = '0;
    end

    if (RST) begin
      ir_we_c    = 1'b0;
      inst_end_c = 1'b0;
    end
  end

  // State register with synchronous reset; a reset aborts any instruction in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= RUN;
      stage_q   <= ST_IF;
      idx_q     <= 5'd0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      idx_q     <= idx_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      wait_q    <= wait_d;
    end
  end

  assign stage    = stage_q;
  assign inst_idx = idx_q;
  assign ir_we    = ir_we_c;
  assign inst_end = inst_end_c;
  assign retired  = retired_q;
  assign halted   = halted_q;
  assign illegal  = illegal_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_mc_stage_sequencer.sv
// Directed testbench for mc_stage_sequencer: stage traces, stalls,
// illegal fetch, halt and wait timeout against hand-computed values.
module tb_mc_stage_sequencer;

  localparam int CntW   = 32;
  localparam int WaitLm = 255;

  logic            CLK;
  logic            RST;
  logic [31:0]     imem_rdata;
  logic            imem_ready;
  logic            dmem_ready;
  logic            halt_req;
  logic [2:0]      stage;
  logic [4:0]      inst_idx;
  logic            ir_we;
  logic            inst_end;
  logic [CntW-1:0] retired;
  logic            halted;
  logic            illegal;
  logic            timeout;

  int nTests;
  int nFail;

  mc_stage_sequencer #(.CNT_WIDTH(CntW), .WAIT_LIMIT(WaitLm)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .halt_req   (halt_req),
    .stage      (stage),
    .inst_idx   (inst_idx),
    .ir_we      (ir_we),
    .inst_end   (inst_end),
    .retired    (retired),
    .halted     (halted),
    .illegal    (illegal),
    .timeout    (timeout)
  );

  // Free-running 10 ns clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Hold reset for two edges, then release with all inputs idle.
  task automatic doReset();
    RST        = 1'b1;
    imem_rdata = 32'h0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    halt_req   = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // Run one instruction to its inst_end (bounded), recording the stage trace
  // as octal digits, cycle count and strobe positions. dmem_ready is held
  // low for the first dmemLow MEM cycles; halt_req rises once haltStage is seen.
  task automatic applyStimulus(input logic [31:0] instr, input int dmemLow,
                               input int haltStage, output logic [31:0] trace,
                               output int cycles, output int irweAt,
                               output int irweCount, output int endCount);
    int  memWait;
    bit  done;
    trace     = 32'h0;
    cycles    = 0;
    irweAt    = 0;
    irweCount = 0;
    endCount  = 0;
    memWait   = 0;
    done      = 1'b0;
    halt_req  = 1'b0;
    for (int c = 1; c <= 20 && !done; c++) begin
      imem_rdata = instr;
      imem_ready = 1'b1;
      if (int'(stage) == haltStage) halt_req = 1'b1;
      if (stage == 3'd3) begin
        dmem_ready = (memWait >= dmemLow);
        memWait++;
      end else begin
        dmem_ready = 1'b1;
      end
      #1;
      trace  = (trace << 3) | {29'h0, stage};
      cycles = c;
      if (ir_we) begin
        irweCount++;
        irweAt = c;
      end
      if (inst_end) begin
        endCount++;
        done = 1'b1;
      end
      tick();
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    #1;
    nTests++; if (stage !== 3'd0) begin nFail++; $display("[TB] FAIL reset_stage: got %0d want 0", stage); end
    nTests++; if (inst_idx !== 5'd0) begin nFail++; $display("[TB] FAIL reset_idx: got %0d want 0", inst_idx); end
    nTests++; if (ir_we !== 1'b0) begin nFail++; $display("[TB] FAIL reset_ir_we: got %0b want 0", ir_we); end
    nTests++; if (inst_end !== 1'b0) begin nFail++; $display("[TB] FAIL reset_inst_end: got %0b want 0", inst_end); end
    nTests++; if (retired !== 32'd0) begin nFail++; $display("[TB] FAIL reset_retired: got %0d want 0", retired); end
    nTests++; if ({halted, illegal, timeout} !== 3'b000) begin nFail++; $display("[TB] FAIL reset_flags: got %b want 000", {halted, illegal, timeout}); end
  endtask

  task automatic test_add();
    logic [31:0] tr;
    int cyc, wAt, wCnt, eCnt;
    applyStimulus(32'h002081B3, 0, 7, tr, cyc, wAt, wCnt, eCnt);
    nTests++; if (tr !== 32'o124) begin nFail++; $display("[TB] FAIL add_trace: got %o want 124", tr); end
    nTests++; if (cyc !== 4) begin nFail++; $display("[TB] FAIL add_cycles: got %0d want 4", cyc); end
    nTests++; if (wAt !== 1 || wCnt !== 1) begin nFail++; $display("[TB] FAIL add_ir_we: at %0d count %0d want at 1 count 1", wAt, wCnt); end
    nTests++; if (eCnt !== 1) begin nFail++; $display("[TB] FAIL add_inst_end: got %0d want 1", eCnt); end
    nTests++; if (inst_idx !== 5'd0) begin nFail++; $display("[TB] FAIL add_idx: got %0d want 0", inst_idx); end
    nTests++; if (retired !== 32'd1) begin nFail++; $display("[TB] FAIL add_retired: got %0d want 1", retired); end
    nTests++; if (stage !== 3'd0) begin nFail++; $display("[TB] FAIL add_back_to_if: got %0d want 0", stage); end
  endtask

  task automatic test_lw_stall();
    logic [31:0] tr;
    int cyc, wAt, wCnt, eCnt;
    applyStimulus(32'h0000A183, 3, 7, tr, cyc, wAt, wCnt, eCnt);
    nTests++; if (tr !== 32'o1233334) begin nFail++; $display("[TB] FAIL lw_trace: got %o want 1233334", tr); end
    nTests++; if (cyc !== 8) begin nFail++; $display("[TB] FAIL lw_cycles: got %0d want 8", cyc); end
    nTests++; if (eCnt !== 1) begin nFail++; $display("[TB] FAIL lw_inst_end: got %0d want 1", eCnt); end
    nTests++; if (inst_idx !== 5'd20) begin nFail++; $display("[TB] FAIL lw_idx: got %0d want 20", inst_idx); end
    nTests++; if (retired !== 32'd2) begin nFail++; $display("[TB] FAIL lw_retired: got %0d want 2", retired); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] tr;
    int cyc, wAt, wCnt, eCnt;
    doReset();
    applyStimulus(32'h123450B7, 0, 7, tr, cyc, wAt, wCnt, eCnt);
    nTests++; if (tr !== 32'o4 || cyc !== 2) begin nFail++; $display("[TB] FAIL lui_trace: got %o in %0d want 4 in 2", tr, cyc); end
    nTests++; if (inst_idx !== 5'd26) begin nFail++; $display("[TB] FAIL lui_idx: got %0d want 26", inst_idx); end
    applyStimulus(32'h008000EF, 0, 7, tr, cyc, wAt, wCnt, eCnt);
    nTests++; if (tr !== 32'o24 || cyc !== 3) begin nFail++; $display("[TB] FAIL jal_trace: got %o in %0d want 24 in 3", tr, cyc); end
    nTests++; if (inst_idx !== 5'd23) begin nFail++; $display("[TB] FAIL jal_idx: got %0d want 23", inst_idx); end
    applyStimulus(32'h0020E463, 0, 7, tr, cyc, wAt, wCnt, eCnt);
    nTests++; if (tr !== 32'o12 || cyc !== 3) begin nFail++; $display("[TB] FAIL bltu_trace: got %o in %0d want 12 in 3", tr, cyc); end
    nTests++; if (inst_idx !== 5'd25) begin nFail++; $display("[TB] FAIL bltu_idx: got %0d want 25", inst_idx); end
    nTests++; if (retired !== 32'd3) begin nFail++; $display("[TB] FAIL b2b_retired: got %0d want 3", retired); end
  endtask

  task automatic test_illegal();
    logic [31:0] tr;
    int cyc, wAt, wCnt, eCnt, extraWe;
    doReset();
    applyStimulus(32'h123450B7, 0, 7, tr, cyc, wAt, wCnt, eCnt);
    imem_rdata = 32'hFFFFFFFF;
    imem_ready = 1'b1;
    #1;
    nTests++; if (ir_we !== 1'b1) begin nFail++; $display("[TB] FAIL illegal_ir_we: got %0b want 1", ir_we); end
    tick();
    nTests++; if (illegal !== 1'b1 || stage !== 3'd0) begin nFail++; $display("[TB] FAIL illegal_flag: illegal %0b stage %0d want 1 0", illegal, stage); end
    nTests++; if (inst_idx !== 5'd26) begin nFail++; $display("[TB] FAIL illegal_idx_kept: got %0d want 26", inst_idx); end
    extraWe = 0;
    imem_rdata = 32'h002081B3;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (ir_we || inst_end) extraWe++;
      tick();
    end
    nTests++; if (extraWe !== 0 || retired !== 32'd1) begin nFail++; $display("[TB] FAIL err_holds: strobes %0d retired %0d want 0 1", extraWe, retired); end
    doReset();
    #1;
    nTests++; if (illegal !== 1'b0) begin nFail++; $display("[TB] FAIL illegal_cleared: got %0b want 0", illegal); end
    halt_req   = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hFFFFFFFF;
    tick();
    nTests++; if (illegal !== 1'b1 || halted !== 1'b0) begin nFail++; $display("[TB] FAIL illegal_beats_halt: illegal %0b halted %0b want 1 0", illegal, halted); end
    halt_req = 1'b0;
  endtask

  task automatic test_halt();
    logic [31:0] tr;
    int cyc, wAt, wCnt, eCnt, extraWe;
    doReset();
    applyStimulus(32'h00500093, 0, 2, tr, cyc, wAt, wCnt, eCnt);
    nTests++; if (tr !== 32'o124 || eCnt !== 1) begin nFail++; $display("[TB] FAIL halt_mid_trace: got %o ends %0d want 124 1", tr, eCnt); end
    nTests++; if (inst_idx !== 5'd10) begin nFail++; $display("[TB] FAIL addi_idx: got %0d want 10", inst_idx); end
    nTests++; if (halted !== 1'b1 || stage !== 3'd0 || retired !== 32'd1) begin nFail++; $display("[TB] FAIL halt_state: halted %0b stage %0d retired %0d want 1 0 1", halted, stage, retired); end
    halt_req   = 1'b0;
    imem_ready = 1'b1;
    extraWe    = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (ir_we || inst_end) extraWe++;
      tick();
    end
    nTests++; if (extraWe !== 0 || halted !== 1'b1) begin nFail++; $display("[TB] FAIL halt_holds: strobes %0d halted %0b want 0 1", extraWe, halted); end
    doReset();
    halt_req   = 1'b1;
    imem_ready = 1'b0;
    #1;
    nTests++; if (ir_we !== 1'b0) begin nFail++; $display("[TB] FAIL halt_if_no_fetch: got %0b want 0", ir_we); end
    tick();
    nTests++; if (halted !== 1'b1 || retired !== 32'd0) begin nFail++; $display("[TB] FAIL halt_in_if: halted %0b retired %0d want 1 0", halted, retired); end
    halt_req = 1'b0;
  endtask

  task automatic test_timeout();
    doReset();
    imem_ready = 1'b0;
    for (int i = 0; i < WaitLm - 1; i++) tick();
    nTests++; if (timeout !== 1'b0) begin nFail++; $display("[TB] FAIL timeout_early: got %0b want 0", timeout); end
    tick();
    nTests++; if (timeout !== 1'b1 || stage !== 3'd0) begin nFail++; $display("[TB] FAIL timeout_set: timeout %0b stage %0d want 1 0", timeout, stage); end
    nTests++; if (retired !== 32'd0 || illegal !== 1'b0) begin nFail++; $display("[TB] FAIL timeout_side: retired %0d illegal %0b want 0 0", retired, illegal); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    nTests = 0;
    nFail  = 0;
    test_reset();
    test_add();
    test_lw_stall();
    test_back_to_back();
    test_illegal();
    test_halt();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
